// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: Dino run/over/restart sequencer, high-score latch and day/night fade (fade built only with DAYNIGHT_EN).
// Latency: every output follows the key/collide/score/game_tick condition that caused it by one clk.
// Backpressure: none; all inputs are sampled every cycle.
module game_flow_ctrl #(
  parameter int unsigned SCORE_W    = 16,
  parameter int unsigned DN_PERIOD  = 16'h700,
  parameter int unsigned NIGHT_LEN  = 16'h200,
  parameter int unsigned FADE_TICKS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         key,
  input  logic               collide,
  input  logic               game_tick,
  input  logic [SCORE_W-1:0] score,
  output logic               game_rst,
  output logic               over,
  output logic [SCORE_W-1:0] hi,
  output logic               new_hi,
  output logic [3:0]         bg,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    FROZEN    = 3'd0,
    RELEASE   = 3'd1,
    RUN       = 3'd2,
    OVER_HOLD = 3'd3,
    OVER_WAIT = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   key_held;
  logic   hit;

  assign key_held = |key;
  assign hit      = (state_q == RUN) && collide;
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FROZEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Every start/restart passes through RELEASE so the start key cannot double as a jump.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FROZEN:    if (key_held)  state_d = RELEASE;
      RELEASE:   if (!key_held) state_d = RUN;
      RUN:       if (collide)   state_d = OVER_HOLD;
      OVER_HOLD: if (!key_held) state_d = OVER_WAIT;
      OVER_WAIT: if (key_held)  state_d = RELEASE;
      default:                  state_d = FROZEN;
    endcase
  end

  always_comb begin
    game_rst = 1'b1;
    over     = 1'b0;
    case (state_q)
      FROZEN, RELEASE: begin
        game_rst = 1'b1;
        over     = 1'b0;
      end
      RUN: begin
        game_rst = 1'b0;
        over     = 1'b0;
      end
      OVER_HOLD, OVER_WAIT: begin
        game_rst = 1'b0;
        over     = 1'b1;
      end
      default: begin
        game_rst = 1'b1;
        over     = 1'b0;
      end
    endcase
  end

  // hi survives game_rst; only the system reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      new_hi <= 1'b0;
    end else begin
      new_hi <= 1'b0;
      if (hit && (score > hi)) begin
        hi     <= score;
        new_hi <= 1'b1;
      end
    end
  end

`ifdef DAYNIGHT_EN
  localparam int unsigned        CNT_W     = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FADE_TICKS - 1);
  localparam logic [SCORE_W-1:0] PERIOD    = SCORE_W'(DN_PERIOD);
  localparam logic [SCORE_W-1:0] NIGHT_END = SCORE_W'(NIGHT_LEN);

  logic               night;
  logic [CNT_W-1:0]   tick_cnt;
  logic [SCORE_W-1:0] phase;
  logic               in_run;

  assign phase  = score % PERIOD;
  assign in_run = (state_q == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      night <= 1'b0;
    end else if (game_rst) begin
      night <= 1'b0;
    end else if (in_run) begin
      if ((score != '0) && (phase == '0)) begin
        night <= 1'b1;
      end else if (phase == NIGHT_END) begin
        night <= 1'b0;
      end
    end
  end

  // bg steps one grey level per FADE_TICKS ticks toward the current target and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bg       <= 4'hF;
    end else if (game_rst) begin
      tick_cnt <= '0;
      bg       <= 4'hF;
    end else if (in_run && game_tick) begin
      if (tick_cnt == CNT_LAST) begin
        tick_cnt <= '0;
        if (night && (bg != 4'h0)) begin
          bg <= bg - 4'd1;
        end else if (!night && (bg != 4'hF)) begin
          bg <= bg + 4'd1;
        end
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_game_tick;

  assign unused_game_tick = game_tick;
  assign bg               = 4'hF;
`endif

endmodule
